// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one tx_mux path between N_CH decision channels, one pending order per channel.
// Latency: request edge k -> tx_dv high after edge k+1 when idle and tx_ready; one order outstanding until tx_done or timeout.
// Backpressure: tx_ready low holds grants off; newer requests overwrite older pending ones and are counted in drop_cnt.
module tx_arbiter #(
   parameter int         N_CH        = 4,
   parameter logic [7:0] ADDR_BASE   = 8'd0,
   parameter int         TIMEOUT     = 1024,
   parameter int         FILTER_HOLD = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N_CH-1:0]      req_dv,
   input  logic [8*N_CH-1:0]    req_buysell,
   input  logic [32*N_CH-1:0]   req_timestamp,
   input  logic                 tx_ready,
   input  logic                 tx_done,
   output logic [7:0]           tx_addr,
   output logic [7:0]           tx_buysell,
   output logic [31:0]          tx_timestamp,
   output logic                 tx_dv,
   output logic [N_CH-1:0]      pending,
   output logic [7:0]           drop_cnt,
   output logic [7:0]           timeout_cnt
);

   localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     rr_q, rr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [N_CH-1:0]   pend_q, pend_d;
   logic [7:0]        bs_q [N_CH];
   logic [7:0]        bs_d [N_CH];
   logic [31:0]       ts_q [N_CH];
   logic [31:0]       ts_d [N_CH];
   logic [7:0]        tx_addr_q, tx_addr_d;
   logic [7:0]        tx_bs_q, tx_bs_d;
   logic [31:0]       tx_ts_q, tx_ts_d;
   logic              tx_dv_q, tx_dv_d;
   logic [7:0]        drop_q, drop_d;
   logic [7:0]        tout_q, tout_d;

   logic              hi_vld, lo_vld;
   logic [PW-1:0]     hi_idx, lo_idx;
   logic [PW-1:0]     gnt_idx;
   logic              do_grant;
   logic [4:0]        n_drop;
   logic [8:0]        drop_sum;

   // Round-robin search: lowest pending index at or above rr_q, else lowest pending overall (wrap).
   always_comb begin
      hi_vld = 1'b0;
      hi_idx = '0;
      lo_vld = 1'b0;
      lo_idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            lo_vld = 1'b1;
            lo_idx = PW'(i);
            if (i >= int'(rr_q)) begin
               hi_vld = 1'b1;
               hi_idx = PW'(i);
            end
         end
      end
      gnt_idx  = hi_vld ? hi_idx : lo_idx;
      do_grant = (state_q == S_IDLE) && tx_ready && (hi_vld || lo_vld);
   end

   // Per-channel capture: newest request wins; overwriting a pending entry not being granted counts a drop.
   always_comb begin
      pend_d = pend_q;
      bs_d   = bs_q;
      ts_d   = ts_q;
      n_drop = '0;
      if (do_grant) begin
         pend_d[gnt_idx] = 1'b0;
      end
      for (int i = 0; i < N_CH; i++) begin
         if (req_dv[i] && !((FILTER_HOLD != 0) && (req_buysell[8*i +: 8] == 8'd0))) begin
            if (pend_q[i] && !(do_grant && (gnt_idx == PW'(i)))) begin
               n_drop = n_drop + 5'd1;
            end
            pend_d[i] = 1'b1;
            bs_d[i]   = req_buysell[8*i +: 8];
            ts_d[i]   = req_timestamp[32*i +: 32];
         end
      end
      drop_sum = 9'(drop_q) + 9'(n_drop);
      drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   // Issue FSM: grant from IDLE, then wait for tx_done or the timeout before granting again.
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      cnt_d     = cnt_q;
      tx_dv_d   = 1'b0;
      tx_addr_d = tx_addr_q;
      tx_bs_d   = tx_bs_q;
      tx_ts_d   = tx_ts_q;
      tout_d    = tout_q;
      case (state_q)
         S_IDLE: begin
            if (do_grant) begin
               tx_dv_d   = 1'b1;
               tx_addr_d = ADDR_BASE + 8'(gnt_idx);
               tx_bs_d   = bs_q[gnt_idx];
               tx_ts_d   = ts_q[gnt_idx];
               rr_d      = (gnt_idx == PW'(N_CH - 1)) ? '0 : gnt_idx + PW'(1);
               cnt_d     = '0;
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (tx_done) begin
               state_d = S_IDLE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = S_IDLE;
               if (tout_q != 8'hFF) begin
                  tout_d = tout_q + 8'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset abandons any outstanding order and clears all counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         rr_q      <= '0;
         cnt_q     <= '0;
         pend_q    <= '0;
         tx_addr_q <= '0;
         tx_bs_q   <= '0;
         tx_ts_q   <= '0;
         tx_dv_q   <= 1'b0;
         drop_q    <= '0;
         tout_q    <= '0;
         for (int i = 0; i < N_CH; i++) begin
            bs_q[i] <= '0;
            ts_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         tx_addr_q <= tx_addr_d;
         tx_bs_q   <= tx_bs_d;
         tx_ts_q   <= tx_ts_d;
         tx_dv_q   <= tx_dv_d;
         drop_q    <= drop_d;
         tout_q    <= tout_d;
         for (int i = 0; i < N_CH; i++) begin
            bs_q[i] <= bs_d[i];
            ts_q[i] <= ts_d[i];
         end
      end
   end

   assign tx_addr      = tx_addr_q;
   assign tx_buysell   = tx_bs_q;
   assign tx_timestamp = tx_ts_q;
   assign tx_dv        = tx_dv_q;
   assign pending      = pend_q;
   assign drop_cnt     = drop_q;
   assign timeout_cnt  = tout_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: table of per-edge vectors plus directed timeout, saturation, filter and reset sequences.
// Latency: each vector is applied before an edge and outputs are compared 1 time unit after that edge.
// Backpressure: tx_ready/tx_done are driven directly from the vectors.
module tb_tx_arbiter;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [3:0]    req_dv = '0;
   logic [31:0]   req_buysell = '0;
   logic [127:0]  req_timestamp = '0;
   logic          tx_ready = 1'b0;
   logic          tx_done = 1'b0;
   logic [7:0]    tx_addr, tx_buysell, drop_cnt, timeout_cnt;
   logic [31:0]   tx_timestamp;
   logic          tx_dv;
   logic [3:0]    pending;

   logic [3:0]    nf_req_dv = '0;
   logic [31:0]   nf_req_buysell = '0;
   logic [127:0]  nf_req_timestamp = '0;
   logic          nf_tx_ready = 1'b0;
   logic          nf_tx_done = 1'b0;
   logic [7:0]    nf_tx_addr, nf_tx_buysell, nf_drop_cnt, nf_timeout_cnt;
   logic [31:0]   nf_tx_timestamp;
   logic          nf_tx_dv;
   logic [3:0]    nf_pending;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tx_arbiter #(.N_CH(4), .ADDR_BASE(8'h00), .TIMEOUT(8), .FILTER_HOLD(1)) dut (
      .clk(clk), .reset_n(reset_n), .req_dv(req_dv), .req_buysell(req_buysell),
      .req_timestamp(req_timestamp), .tx_ready(tx_ready), .tx_done(tx_done),
      .tx_addr(tx_addr), .tx_buysell(tx_buysell), .tx_timestamp(tx_timestamp),
      .tx_dv(tx_dv), .pending(pending), .drop_cnt(drop_cnt), .timeout_cnt(timeout_cnt)
   );

   tx_arbiter #(.N_CH(4), .ADDR_BASE(8'hFE), .TIMEOUT(8), .FILTER_HOLD(0)) dut_nf (
      .clk(clk), .reset_n(reset_n), .req_dv(nf_req_dv), .req_buysell(nf_req_buysell),
      .req_timestamp(nf_req_timestamp), .tx_ready(nf_tx_ready), .tx_done(nf_tx_done),
      .tx_addr(nf_tx_addr), .tx_buysell(nf_tx_buysell), .tx_timestamp(nf_tx_timestamp),
      .tx_dv(nf_tx_dv), .pending(nf_pending), .drop_cnt(nf_drop_cnt), .timeout_cnt(nf_timeout_cnt)
   );

   typedef struct {
      logic          rst;
      logic [3:0]    dv;
      logic [31:0]   bs;
      logic [127:0]  ts;
      logic          rdy;
      logic          done;
      logic          e_dv;
      logic [7:0]    e_addr;
      logic [7:0]    e_bs;
      logic [31:0]   e_ts;
      logic [3:0]    e_pend;
      logic [7:0]    e_drop;
   } vec_t;

   vec_t vq[$];

   function automatic logic [31:0] b(input int ch, input logic [7:0] v);
      return 32'(v) << (8 * ch);
   endfunction

   function automatic logic [127:0] t(input int ch, input logic [31:0] v);
      return 128'(v) << (32 * ch);
   endfunction

   task automatic add(input logic rst, input logic [3:0] dv, input logic [31:0] bs, input logic [127:0] ts,
                      input logic rdy, input logic done, input logic e_dv, input logic [7:0] e_addr,
                      input logic [7:0] e_bs, input logic [31:0] e_ts, input logic [3:0] e_pend,
                      input logic [7:0] e_drop);
      vec_t v;
      v.rst = rst; v.dv = dv; v.bs = bs; v.ts = ts; v.rdy = rdy; v.done = done;
      v.e_dv = e_dv; v.e_addr = e_addr; v.e_bs = e_bs; v.e_ts = e_ts; v.e_pend = e_pend; v.e_drop = e_drop;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_main(input string tag, input logic e_dv, input logic [7:0] e_addr, input logic [7:0] e_bs,
                           input logic [31:0] e_ts, input logic [3:0] e_pend, input logic [7:0] e_drop,
                           input logic [7:0] e_to);
      chk({tag, "_dv"}, 128'(tx_dv), 128'(e_dv));
      chk({tag, "_addr"}, 128'(tx_addr), 128'(e_addr));
      chk({tag, "_bs"}, 128'(tx_buysell), 128'(e_bs));
      chk({tag, "_ts"}, 128'(tx_timestamp), 128'(e_ts));
      chk({tag, "_pend"}, 128'(pending), 128'(e_pend));
      chk({tag, "_drop"}, 128'(drop_cnt), 128'(e_drop));
      chk({tag, "_tout"}, 128'(timeout_cnt), 128'(e_to));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req_dv = '0; req_buysell = '0; req_timestamp = '0; tx_ready = 1'b0; tx_done = 1'b0;
      nf_req_dv = '0; nf_req_buysell = '0; nf_req_timestamp = '0; nf_tx_ready = 1'b0; nf_tx_done = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic drive(input logic [3:0] dv, input logic [31:0] bs, input logic [127:0] ts,
                        input logic rdy, input logic done);
      req_dv = dv; req_buysell = bs; req_timestamp = ts; tx_ready = rdy; tx_done = done;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Single request, then a second channel held off while WAIT.
      add(1, 4'b0000, 0, 0, 1, 0,  0, 8'd0, 8'd0, 32'h0, 4'b0000, 8'd0);
      add(0, 4'b0100, b(2, 2), t(2, 32'h1234), 1, 0,  0, 8'd0, 8'd0, 32'h0, 4'b0100, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 0,  1, 8'd2, 8'd2, 32'h1234, 4'b0000, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 0,  0, 8'd2, 8'd2, 32'h1234, 4'b0000, 8'd0);
      add(0, 4'b0001, b(0, 1), t(0, 32'h55), 1, 0,  0, 8'd2, 8'd2, 32'h1234, 4'b0001, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 0,  0, 8'd2, 8'd2, 32'h1234, 4'b0001, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 1,  0, 8'd2, 8'd2, 32'h1234, 4'b0001, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 0,  1, 8'd0, 8'd1, 32'h55, 4'b0000, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 1,  0, 8'd0, 8'd1, 32'h55, 4'b0000, 8'd0);
      // Round-robin over all four channels, tx_done three cycles after each issue.
      add(1, 4'b0000, 0, 0, 1, 0,  0, 8'd0, 8'd0, 32'h0, 4'b0000, 8'd0);
      add(0, 4'b1111, {8'd2, 8'd1, 8'd2, 8'd1}, {32'hD, 32'hC, 32'hB, 32'hA}, 1, 0,
          0, 8'd0, 8'd0, 32'h0, 4'b1111, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 0,  1, 8'd0, 8'd1, 32'hA, 4'b1110, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 0,  0, 8'd0, 8'd1, 32'hA, 4'b1110, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 0,  0, 8'd0, 8'd1, 32'hA, 4'b1110, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 1,  0, 8'd0, 8'd1, 32'hA, 4'b1110, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 0,  1, 8'd1, 8'd2, 32'hB, 4'b1100, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 0,  0, 8'd1, 8'd2, 32'hB, 4'b1100, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 0,  0, 8'd1, 8'd2, 32'hB, 4'b1100, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 1,  0, 8'd1, 8'd2, 32'hB, 4'b1100, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 0,  1, 8'd2, 8'd1, 32'hC, 4'b1000, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 0,  0, 8'd2, 8'd1, 32'hC, 4'b1000, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 0,  0, 8'd2, 8'd1, 32'hC, 4'b1000, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 1,  0, 8'd2, 8'd1, 32'hC, 4'b1000, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 0,  1, 8'd3, 8'd2, 32'hD, 4'b0000, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 0,  0, 8'd3, 8'd2, 32'hD, 4'b0000, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 0,  0, 8'd3, 8'd2, 32'hD, 4'b0000, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 1,  0, 8'd3, 8'd2, 32'hD, 4'b0000, 8'd0);
      add(0, 4'b1001, b(0, 2) | b(3, 1), t(0, 32'hE) | t(3, 32'hF), 1, 0,
          0, 8'd3, 8'd2, 32'hD, 4'b1001, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 0,  1, 8'd0, 8'd2, 32'hE, 4'b1000, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 1,  0, 8'd0, 8'd2, 32'hE, 4'b1000, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 0,  1, 8'd3, 8'd1, 32'hF, 4'b0000, 8'd0);
      add(0, 4'b0000, 0, 0, 1, 1,  0, 8'd3, 8'd1, 32'hF, 4'b0000, 8'd0);
      // Overwrite while blocked, then capture on the same edge as the grant of that channel.
      add(1, 4'b0000, 0, 0, 0, 0,  0, 8'd0, 8'd0, 32'h0, 4'b0000, 8'd0);
      add(0, 4'b0010, b(1, 1), t(1, 32'h11), 0, 0,  0, 8'd0, 8'd0, 32'h0, 4'b0010, 8'd0);
      add(0, 4'b0010, b(1, 2), t(1, 32'h22), 0, 0,  0, 8'd0, 8'd0, 32'h0, 4'b0010, 8'd1);
      add(0, 4'b0000, 0, 0, 0, 0,  0, 8'd0, 8'd0, 32'h0, 4'b0010, 8'd1);
      add(0, 4'b0000, 0, 0, 1, 0,  1, 8'd1, 8'd2, 32'h22, 4'b0000, 8'd1);
      add(0, 4'b0000, 0, 0, 1, 1,  0, 8'd1, 8'd2, 32'h22, 4'b0000, 8'd1);
      add(0, 4'b0000, 0, 0, 1, 0,  0, 8'd1, 8'd2, 32'h22, 4'b0000, 8'd1);
      add(0, 4'b0100, b(2, 1), t(2, 32'h31), 1, 0,  0, 8'd1, 8'd2, 32'h22, 4'b0100, 8'd1);
      add(0, 4'b0100, b(2, 2), t(2, 32'h32), 1, 0,  1, 8'd2, 8'd1, 32'h31, 4'b0100, 8'd1);
      add(0, 4'b0000, 0, 0, 1, 1,  0, 8'd2, 8'd1, 32'h31, 4'b0100, 8'd1);
      add(0, 4'b0000, 0, 0, 1, 0,  1, 8'd2, 8'd2, 32'h32, 4'b0000, 8'd1);
      add(0, 4'b0000, 0, 0, 1, 1,  0, 8'd2, 8'd2, 32'h32, 4'b0000, 8'd1);

      for (int i = 0; i < vq.size(); i++) begin
         if (vq[i].rst) do_reset();
         drive(vq[i].dv, vq[i].bs, vq[i].ts, vq[i].rdy, vq[i].done);
         tick();
         chk_main($sformatf("row%0d", i), vq[i].e_dv, vq[i].e_addr, vq[i].e_bs, vq[i].e_ts,
                  vq[i].e_pend, vq[i].e_drop, 8'd0);
      end

      // Timeout after 8 WAIT edges, then the queued channel issues; then drop_cnt saturation.
      do_reset();
      drive(4'b0010, b(1, 1), t(1, 32'h71), 1, 0);
      tick();
      chk("to_pend", 128'(pending), 128'(4'b0010));
      drive(4'b0000, 0, 0, 1, 0);
      tick();
      chk("to_grant_dv", 128'(tx_dv), 128'(1'b1));
      chk("to_grant_addr", 128'(tx_addr), 128'(8'd1));
      drive(4'b0100, b(2, 2), t(2, 32'h72), 1, 0);
      tick();
      drive(4'b0000, 0, 0, 1, 0);
      repeat (6) tick();
      chk("to_edge7_tout", 128'(timeout_cnt), 128'(8'd0));
      chk("to_edge7_dv", 128'(tx_dv), 128'(1'b0));
      chk("to_edge7_pend", 128'(pending), 128'(4'b0100));
      tick();
      chk("to_edge8_tout", 128'(timeout_cnt), 128'(8'd1));
      chk("to_edge8_dv", 128'(tx_dv), 128'(1'b0));
      tick();
      chk_main("to_next", 1'b1, 8'd2, 8'd2, 32'h72, 4'b0000, 8'd0, 8'd1);
      drive(4'b0001, b(0, 1), t(0, 32'h1), 0, 0);
      repeat (260) tick();
      chk("sat_drop", 128'(drop_cnt), 128'(8'd255));
      chk("sat_tout", 128'(timeout_cnt), 128'(8'd2));
      chk("sat_pend", 128'(pending), 128'(4'b0001));

      // Hold filter: filtering instance ignores buysell 0, non-filtering instance issues it.
      do_reset();
      drive(4'b0001, b(0, 0), t(0, 32'h5), 1, 0);
      nf_req_dv = 4'b0001; nf_req_buysell = b(0, 0); nf_req_timestamp = t(0, 32'h5); nf_tx_ready = 1'b1;
      tick();
      chk("flt_pend", 128'(pending), 128'(4'b0000));
      chk("nf_pend", 128'(nf_pending), 128'(4'b0001));
      drive(4'b0000, 0, 0, 1, 0);
      nf_req_dv = '0;
      tick();
      chk("flt_dv", 128'(tx_dv), 128'(1'b0));
      chk("nf_dv", 128'(nf_tx_dv), 128'(1'b1));
      chk("nf_addr", 128'(nf_tx_addr), 128'(8'hFE));
      chk("nf_bs", 128'(nf_tx_buysell), 128'(8'd0));
      chk("nf_ts", 128'(nf_tx_timestamp), 128'(32'h5));
      nf_tx_done = 1'b1;
      tick();
      chk("flt_dv2", 128'(tx_dv), 128'(1'b0));
      chk("flt_pend2", 128'(pending), 128'(4'b0000));
      nf_tx_done = 1'b0;
      nf_req_dv = 4'b1000; nf_req_buysell = b(3, 1); nf_req_timestamp = t(3, 32'h6);
      tick();
      nf_req_dv = '0;
      tick();
      chk("nf_wrap_dv", 128'(nf_tx_dv), 128'(1'b1));
      chk("nf_wrap_addr", 128'(nf_tx_addr), 128'(8'h01));

      // Asynchronous reset in WAIT with ch1 pending.
      do_reset();
      drive(4'b1000, b(3, 2), t(3, 32'h99), 1, 0);
      tick();
      drive(4'b0010, b(1, 1), t(1, 32'h41), 1, 0);
      tick();
      chk_main("rs_grant", 1'b1, 8'd3, 8'd2, 32'h99, 4'b0010, 8'd0, 8'd0);
      drive(4'b0010, b(1, 2), t(1, 32'h42), 1, 0);
      tick();
      drive(4'b0000, 0, 0, 1, 0);
      tick();
      chk_main("rs_pre", 1'b0, 8'd3, 8'd2, 32'h99, 4'b0010, 8'd1, 8'd0);
      #2 reset_n = 1'b0;
      #1;
      chk_main("rs_async", 1'b0, 8'd0, 8'd0, 32'h0, 4'b0000, 8'd0, 8'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      drive(4'b0000, 0, 0, 1, 0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("rs_idle%0d_dv", k), 128'(tx_dv), 128'(1'b0));
         chk($sformatf("rs_idle%0d_pend", k), 128'(pending), 128'(4'b0000));
      end
      drive(4'b0100, b(2, 1), t(2, 32'h77), 1, 0);
      tick();
      drive(4'b0000, 0, 0, 1, 0);
      tick();
      chk_main("rs_new", 1'b1, 8'd2, 8'd1, 32'h77, 4'b0000, 8'd0, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Shares the single tx_mux output path between N_CH per-address decision channels; each channel has its own timestamp and algorithm chain.
- Holds one pending order per channel, picks channels round-robin, and issues one order at a time to tx_mux.
- Waits for tx_mux to finish, with a timeout for recovery.
- Sits between the per-address system/timestamp outputs and tx_mux.

Parameters:
- N_CH, 4, number of requesting channels (2..16).
- ADDR_BASE, 0, tx_addr value of channel 0; channel i maps to ADDR_BASE+i (8-bit, wraps mod 256).
- TIMEOUT, 1024, cycles allowed in WAIT before forced return to IDLE (>=2).
- FILTER_HOLD, 1, when 1, requests with buysell==0 are ignored.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_dv  in  N_CH  per-channel one-cycle request strobe.
- req_buysell  in  8*N_CH  per-channel decision, channel i at bits [8i+7:8i]; 0=hold, 1=sell, 2=buy.
- req_timestamp  in  32*N_CH  per-channel timestamp, channel i at bits [32i+31:32i].
- tx_ready  in  1  tx_mux can accept an order.
- tx_done  in  1  one-cycle pulse when tx_mux has finished the issued order.
- tx_addr  out  8  address of the issued order.
- tx_buysell  out  8  decision of the issued order.
- tx_timestamp  out  32  timestamp of the issued order.
- tx_dv  out  1  one-cycle issue strobe.
- pending  out  N_CH  per-channel pending flags.
- drop_cnt  out  8  saturating count of overwritten requests.
- timeout_cnt  out  8  saturating count of WAIT timeouts.

Behaviour:
- Reset (async, reset_n low):
  - All outputs are 0, pending is all 0, rr_ptr=0, state=IDLE, wait counter=0.
  - Reset mid-WAIT abandons the order silently; counters do not increment.
- Capture:
  - On a clock edge with req_dv[i]=1, channel i's buysell/timestamp are stored and pending[i] is set.
  - With FILTER_HOLD=1 and buysell=0, the request is ignored.
  - If pending[i] is already set and is not being granted on this edge, the new request overwrites it (newest wins) and drop_cnt increments, saturating at 255.
  - If channel i is granted on the same edge, the old entry is issued, the new entry becomes pending, and no drop is counted.
- FSM states: IDLE, WAIT.
  - IDLE: if tx_ready=1 and any pending bit is set, grant the first set bit searching from rr_ptr upward with wrap.
  - On a grant edge:
    - tx_addr=ADDR_BASE+g, tx_buysell and tx_timestamp load the stored entry, and tx_dv=1 for exactly one cycle.
    - pending[g] clears (unless re-captured), rr_ptr=(g+1) mod N_CH, wait counter=0, state goes to WAIT.
  - IDLE with no pending bits or tx_ready=0: tx_dv=0, state and pointer hold.
  - WAIT: tx_dv=0 and no grants; capture continues.
    - tx_done=1 -> IDLE.
    - Otherwise, when the counter reaches TIMEOUT-1 -> IDLE and timeout_cnt increments (saturating); else the counter increments.
  - tx_done in IDLE is ignored.
- Latency and output holding:
  - A req_dv at edge k on an idle arbiter with tx_ready=1 and no competition gives tx_dv high during the cycle after edge k+1. That is a 2-edge latency.
  - Next grant is possible on the edge after tx_done is seen: the WAIT->IDLE edge, then the grant edge.
  - tx_addr, tx_buysell and tx_timestamp hold their last values until the next grant.
- Fairness: with all channels continuously pending, grants cycle 0,1,...,N_CH-1,0.

Test Plan:
- Single request: ch2 req_dv with buysell=2, ts=0x00001234, tx_ready=1 -> tx_dv one cycle 2 edges later, tx_addr=2, tx_buysell=2, tx_timestamp=0x00001234; state WAIT until tx_done.
- Round-robin: ch0..ch3 requested on the same edge, tx_done returned 3 cycles after each tx_dv -> grant order 0,1,2,3; then re-request ch0 and ch3 -> order 0,3.
- Overwrite: ch1 requested twice (buysell 1 then 2) while blocked by tx_ready=0 -> drop_cnt=1; after tx_ready=1, a single issue with tx_buysell=2.
- Filter: FILTER_HOLD=1, ch0 buysell=0 -> pending stays 0 and no tx_dv; with FILTER_HOLD=0 the same stimulus issues tx_buysell=0.
- Timeout: TIMEOUT=8, issue an order and never assert tx_done -> return to IDLE after 8 WAIT cycles, timeout_cnt=1, next pending order issues.
- Reset in WAIT with ch1 pending: assert reset_n=0 -> outputs, pending and counters all 0 immediately (asynchronous); no tx_dv after release until a new request.
